// File: rtl/uart_tx_framer.sv
// Byte-wide UART transmitter: 8N1 frame on a rising edge of tx_start, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and the stop bit (8E1).
module uart_tx_framer #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  // state  | meaning
  // IDLE   | line high, waiting for a rising edge on tx_start
  // START  | start bit (line low)
  // DATA   | data bits D0..D7, LSB first
  // PARITY | even-parity bit (UART_TX_PARITY_EN only)
  // STOP   | stop bit (line high); tx_done on its last cycle
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_d;
  logic [7:0]       shift, shift_d;
  logic [2:0]       bit_idx, bit_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             start_q;
  logic             trig;
  logic             last;
  logic             out_d;
  logic             done_d;

  assign trig = tx_start & ~start_q;
  assign last = (cnt == CNT_LAST);

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = (state == IDLE && trig) ? ^tx_data : parity_q;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end
`endif

  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_d   = bit_idx;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (trig) begin
          shift_d = tx_data;
          bit_d   = 3'd0;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (last) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (last) begin
          cnt_d   = '0;
          shift_d = shift >> 1;
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (last) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they leave flops aligned with the state.
  always_comb begin
    out_d = 1'b1;
    case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  out_d = parity_d;
`endif
      default: out_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      start_q <= 1'b1;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_idx <= bit_d;
      cnt     <= cnt_d;
      start_q <= tx_start;
      tx_out  <= out_d;
      tx_busy <= (state_d != IDLE);
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer at CLKS_PER_BIT=10; frame model follows UART_TX_PARITY_EN.
module tb_uart_tx_framer;

  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = C * NB;

  logic       clk_100MHz = 1'b0;
  logic       rst_n      = 1'b0;
  logic       tx_start   = 1'b0;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int   checks = 0;
  int   errors = 0;
  logic exp_bits[$];

  always #5 clk_100MHz = ~clk_100MHz;

  uart_tx_framer #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_out    (tx_out),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  task automatic check(input string tag, input int k, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, k, got, exp);
    end
  endtask

  // Line levels of one frame, one entry per bit cell.
  task automatic build_frame(input logic [7:0] d);
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    exp_bits.push_back(($countones(d) % 2) == 1);
`endif
    exp_bits.push_back(1'b1);
  endtask

  // Triggers one frame and checks every cycle from T+1 onward; hold = cycles tx_start stays
  // high, retrig_at = cycle of a second rising edge during the frame (0 = none).
  task automatic do_frame(input logic [7:0] d, input int hold, input int retrig_at,
                          input logic [7:0] d2, input int tail);
    int total;
    build_frame(d);
    total = ((hold > F) ? hold : F) + tail;
    @(negedge clk_100MHz);
    tx_start = 1'b1;
    tx_data  = d;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk_100MHz);
      check("line", k, tx_out, (k <= F) ? exp_bits[(k-1)/C] : 1'b1);
      check("busy", k, tx_busy, k <= F);
      check("done", k, tx_done, k == F);
      if (k == hold) tx_start = 1'b0;
      if (k == 1 && retrig_at == 0) tx_data = 8'($urandom);
      if (retrig_at > 0 && k == retrig_at - 1) begin
        tx_start = 1'b1;
        tx_data  = d2;
      end
      if (retrig_at > 0 && k == retrig_at + 4) tx_start = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'h5A;
    repeat (3) @(negedge clk_100MHz);
    check("rst_line", 0, tx_out, 1'b1);
    check("rst_busy", 0, tx_busy, 1'b0);
    check("rst_done", 0, tx_done, 1'b0);

    rst_n = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk_100MHz);
      check("held_line", k, tx_out, 1'b1);
      check("held_busy", k, tx_busy, 1'b0);
      check("held_done", k, tx_done, 1'b0);
    end
    tx_start = 1'b0;

    do_frame(8'hA5, 1, 0, 8'h00, 2);
    do_frame(8'($urandom), 500, 0, 8'h00, 3);
    do_frame(8'hA5, 1, 40, 8'h00, F + 5);
    do_frame(8'h07, 1, 0, 8'h00, 2);
    do_frame(8'h03, 1, 0, 8'h00, 0);
    do_frame(8'($urandom), 1, 0, 8'h00, 0);
    do_frame(8'($urandom), 1, 0, 8'h00, 2);
    for (int n = 0; n < 6; n++)
      do_frame(8'($urandom), int'($urandom_range(1, 3)), 0, 8'h00, int'($urandom_range(0, 3)));

    @(negedge clk_100MHz);
    tx_start = 1'b1;
    tx_data  = 8'($urandom);
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk_100MHz);
      if (k == 1) tx_start = 1'b0;
    end
    check("pre_abort_busy", 55, tx_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_line", 55, tx_out, 1'b1);
    check("abort_busy", 55, tx_busy, 1'b0);
    check("abort_done", 55, tx_done, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_100MHz);
      if (k == 3) rst_n = 1'b1;
      check("post_abort_line", k, tx_out, 1'b1);
      check("post_abort_done", k, tx_done, 1'b0);
    end
    do_frame(8'($urandom), 1, 0, 8'h00, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Byte-wide UART transmitter for the UART project: the outbound counterpart of the button-conditioning input path. On a rising edge of the debounced send button it latches `tx_data` and shifts out one 8N1 frame (optionally 8E1) on `tx_out`, LSB first, at a baud rate derived from the 100 MHz system clock. It sits between the debounced button/switch inputs and the board's UART TX pin.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bit/s
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (integer division, 10416 at defaults), clocks per bit cell; must be ≥ 2
- `clk_100MHz`  input  1  system clock; all logic on rising edge
- `rst_n`  input  1  reset, asynchronous assert, active-low
- `tx_start`  input  1  send request (debounced button level); only a rising edge triggers
- `tx_data`  input  8  byte to send; sampled on the triggering cycle only
- `tx_out`  output  1  serial line; idle high
- `tx_busy`  output  1  high while a frame is in progress
- `tx_done`  output  1  one-cycle pulse at the end of the stop bit

## Operation
- Edge detect: register `start_q` holds the previous `tx_start`; `trig = tx_start & ~start_q`. `start_q` updates every cycle, in every state.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: `tx_out`=1, `tx_busy`=0. On `trig`: latch `tx_data` into the shift register, clear the bit counter and baud counter, go to START.
- START: `tx_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx_out` = shift[0]. Each bit lasts CLKS_PER_BIT cycles, then shift right and increment the bit index (3 bits). After index 7 completes, go to PARITY if enabled, else STOP.
- PARITY: `tx_out` = XOR of the latched byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: `tx_out`=1 for CLKS_PER_BIT cycles. On the last cycle, assert `tx_done` for that cycle and go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, clears on every state/bit advance, width $clog2(CLKS_PER_BIT).
- `trig` while not IDLE: ignored, not queued. A level still held high when the FSM returns to IDLE does not retrigger.
- `tx_data` changes after the trigger cycle have no effect on the frame in flight.

## Timing
- Reset (async, `rst_n`=0): `tx_out`=1, `tx_busy`=0, `tx_done`=0, state=IDLE, counters=0, `start_q`=1. Because `start_q` resets to 1, a button held through reset release does not send.
- Reset mid-frame: the line returns high immediately; the frame is aborted with no `tx_done`.
- Latency: trigger in cycle T → `tx_out` falls and `tx_busy` rises at T+1. Both are registered outputs.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity). `tx_busy` stays high for exactly that many cycles.
- `tx_done` is high in the final STOP cycle, the same cycle `tx_busy` is last high.
- Earliest next trigger: the first IDLE cycle after `tx_done`, which gives back-to-back frames with no idle gap beyond the stop bit.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in; an even-parity bit is inserted between D7 and stop; frame is 11 bits.
- Not defined: no PARITY state or logic; 8N1, 10-bit frame.

## Test plan
- Reset with `tx_start`=1 held, then release → `tx_out` stays 1 and `tx_busy` stays 0 for 200 cycles.
- CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10), `tx_data`=8'hA5, pulse `tx_start` → line reads 0,1,0,1,0,0,1,0,1,1 with each bit held 10 cycles; `tx_busy` high for 100 cycles; one `tx_done` pulse in cycle 100.
- Hold `tx_start` high for 500 cycles → exactly one frame, one `tx_done`.
- Second `tx_start` edge at cycle 40 of a frame, with `tx_data` changed to 8'h00 → the frame in flight still sends 8'hA5 and no second frame follows.
- With `UART_TX_PARITY_EN`, `tx_data`=8'h07 → parity bit is 1, frame lasts 110 cycles; with `tx_data`=8'h03 → parity bit is 0.
- Drop `rst_n` at cycle 55 of a frame → `tx_out`=1 asynchronously, no `tx_done`; a new edge after release sends a complete frame.
